// File: rtl/router_pkg.sv
// Shared definitions for the multi-port router.
// Holds the register map addresses, the CTRL bit positions and the
// arbitration-mode encoding used by the router top and its bench.
package router_pkg;

  localparam logic [3:0] ADDR_CTRL    = 4'h0;
  localparam logic [3:0] ADDR_STATUS  = 4'h4;
  localparam logic [3:0] ADDR_CONTEND = 4'h8;

  localparam int CTRL_EN_BIT   = 0;
  localparam int CTRL_MODE_BIT = 1;

  typedef enum logic {
    ARB_FIXED = 1'b0,
    ARB_RR    = 1'b1
  } arb_mode_e;

endpackage

// File: rtl/router_out_fifo.sv
// Per-output FIFO of the multi-port router.
// Ports:
//   clk, rst_n     - clock, synchronous active-low reset (pointers/count only)
//   i_push/i_wdata - write strobe and payload (ignored while full)
//   i_pop          - read strobe (ignored while empty)
//   o_rdata        - head entry, forced to 0 while empty
//   full, empty    - occupancy flags
module router_out_fifo #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_pop,
  output logic [DATA_W-1:0] o_rdata,
  output logic              full,
  output logic              empty
);

  localparam int PW = $clog2(FIFO_DEPTH);

  logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
  logic [PW-1:0]     r_wr_ptr;
  logic [PW-1:0]     r_rd_ptr;
  logic [PW:0]       r_count;

  logic w_push_ok;
  logic w_pop_ok;

  assign full      = (r_count == (PW+1)'(FIFO_DEPTH));
  assign empty     = (r_count == '0);
  assign w_push_ok = i_push & ~full;
  assign w_pop_ok  = i_pop & ~empty;
  // Masking the head keeps the output at 0 after reset without clearing storage.
  assign o_rdata   = empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_wdata;
  end

endmodule

// File: rtl/multi_port_router.sv
// Multi-port router: NUM_IN valid/ready inputs routed by in_addr into
// NUM_OUT output FIFOs, with per-output arbitration and a small register file.
// Optional round-robin arbitration is built only with ROUTER_RR_ARB_EN defined;
// otherwise arbitration is fixed-priority and CTRL bit1 reads 0.
// Ports:
//   clk, rst_n                   - clock, synchronous active-low reset
//   reg_addr/wdata/en/we, rdata  - register access (read data is combinational)
//   in_data/in_addr/in_valid     - per-input payload, destination, valid
//   in_ready                     - per-input ready
//   out_data/out_valid           - per-output FIFO head and non-empty flag
//   out_ready                    - per-output pop strobe
module multi_port_router
  import router_pkg::*;
#(
  parameter int NUM_IN     = 4,
  parameter int NUM_OUT    = 4,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [3:0]                           reg_addr,
  input  logic [31:0]                          reg_wdata,
  input  logic                                 reg_en,
  input  logic                                 reg_we,
  output logic [31:0]                          reg_rdata,
  input  logic [NUM_IN*DATA_W-1:0]             in_data,
  input  logic [NUM_IN*$clog2(NUM_OUT)-1:0]    in_addr,
  input  logic [NUM_IN-1:0]                    in_valid,
  output logic [NUM_IN-1:0]                    in_ready,
  output logic [NUM_OUT*DATA_W-1:0]            out_data,
  output logic [NUM_OUT-1:0]                   out_valid,
  input  logic [NUM_OUT-1:0]                   out_ready
);

  localparam int AW = $clog2(NUM_OUT);
  localparam int PW = $clog2(NUM_IN);

  logic          r_ctrl_en;
`ifdef ROUTER_RR_ARB_EN
  arb_mode_e     r_ctrl_mode;
  logic [PW-1:0] r_ptr [NUM_OUT];
`endif
  logic [31:0]   r_cont_cnt;

  logic               w_reg_wr;
  logic [NUM_IN-1:0]  w_req       [NUM_OUT];
  logic [PW-1:0]      w_gnt_idx   [NUM_OUT];
  logic [DATA_W-1:0]  w_push_data [NUM_OUT];
  logic [NUM_OUT-1:0] w_gnt_vld;
  logic [NUM_OUT-1:0] w_push;
  logic [NUM_OUT-1:0] w_full;
  logic [NUM_OUT-1:0] w_empty;
  logic               w_contend;
  logic [31:0]        w_status;
  logic               w_unused_wdata;

  function automatic logic multi_hot(input logic [NUM_IN-1:0] v);
    return (v & (v - 1'b1)) != '0;
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  assign w_reg_wr = reg_en & reg_we;
`ifdef ROUTER_RR_ARB_EN
  assign w_unused_wdata = ^reg_wdata[31:2];
`else
  assign w_unused_wdata = ^reg_wdata[31:1];
`endif

  always_comb begin : req_gen
    for (int o = 0; o < NUM_OUT; o++) begin
      for (int i = 0; i < NUM_IN; i++) begin
        w_req[o][i] = in_valid[i] && (in_addr[i*AW +: AW] == AW'(o));
      end
    end
  end

  always_comb begin : arb
`ifdef ROUTER_RR_ARB_EN
    logic [PW:0] v_idx;
    v_idx = '0;
`endif
    for (int o = 0; o < NUM_OUT; o++) begin
      w_gnt_vld[o] = 1'b0;
      w_gnt_idx[o] = '0;
`ifdef ROUTER_RR_ARB_EN
      if (r_ctrl_mode == ARB_RR) begin
        // Scan from the pointer upward with wrap; the first requester wins.
        for (int k = 0; k < NUM_IN; k++) begin
          v_idx = {1'b0, r_ptr[o]} + (PW+1)'(k);
          if (v_idx >= (PW+1)'(NUM_IN)) v_idx = v_idx - (PW+1)'(NUM_IN);
          if (!w_gnt_vld[o] && w_req[o][v_idx[PW-1:0]]) begin
            w_gnt_vld[o] = 1'b1;
            w_gnt_idx[o] = v_idx[PW-1:0];
          end
        end
      end else
`endif
      begin
        // Descending scan so the lowest-index requester is written last.
        for (int i = NUM_IN - 1; i >= 0; i--) begin
          if (w_req[o][i]) begin
            w_gnt_vld[o] = 1'b1;
            w_gnt_idx[o] = PW'(i);
          end
        end
      end
    end
  end

  always_comb begin : route
    w_contend = 1'b0;
    for (int o = 0; o < NUM_OUT; o++) begin
      w_push[o]      = rst_n & r_ctrl_en & w_gnt_vld[o] & ~w_full[o];
      w_push_data[o] = '0;
      for (int i = 0; i < NUM_IN; i++) begin
        if (w_gnt_idx[o] == PW'(i)) w_push_data[o] = in_data[i*DATA_W +: DATA_W];
      end
      if (multi_hot(w_req[o])) w_contend = 1'b1;
    end
    // Ready is withheld while full even if the head pops this cycle.
    for (int i = 0; i < NUM_IN; i++) begin
      in_ready[i] = rst_n & r_ctrl_en
                  & w_gnt_vld[in_addr[i*AW +: AW]]
                  & (w_gnt_idx[in_addr[i*AW +: AW]] == PW'(i))
                  & ~w_full[in_addr[i*AW +: AW]];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ctrl_en   <= 1'b1;
`ifdef ROUTER_RR_ARB_EN
      r_ctrl_mode <= ARB_FIXED;
`endif
      r_cont_cnt  <= '0;
    end else begin
      if (w_reg_wr && reg_addr == ADDR_CTRL) begin
        r_ctrl_en   <= reg_wdata[CTRL_EN_BIT];
`ifdef ROUTER_RR_ARB_EN
        r_ctrl_mode <= arb_mode_e'(reg_wdata[CTRL_MODE_BIT]);
`endif
      end
      // A clearing write takes precedence over a same-cycle increment.
      if (w_reg_wr && reg_addr == ADDR_CONTEND) r_cont_cnt <= '0;
      else if (w_contend)                       r_cont_cnt <= sat_inc(r_cont_cnt);
    end
  end

`ifdef ROUTER_RR_ARB_EN
  // Pointers advance only on an accepted beat and only in round-robin mode.
  always_ff @(posedge clk) begin
    for (int o = 0; o < NUM_OUT; o++) begin
      if (!rst_n) begin
        r_ptr[o] <= '0;
      end else if (r_ctrl_mode == ARB_RR && w_push[o]) begin
        r_ptr[o] <= (w_gnt_idx[o] == PW'(NUM_IN - 1)) ? '0 : w_gnt_idx[o] + 1'b1;
      end
    end
  end
`endif

  always_comb begin : regs_rd
    w_status                 = '0;
    w_status[NUM_OUT-1:0]    = ~w_empty;
    w_status[16 +: NUM_OUT]  = w_full;
    reg_rdata                = '0;
    case (reg_addr)
      ADDR_CTRL: begin
        reg_rdata[CTRL_EN_BIT]   = r_ctrl_en;
`ifdef ROUTER_RR_ARB_EN
        reg_rdata[CTRL_MODE_BIT] = r_ctrl_mode;
`endif
      end
      ADDR_STATUS:  reg_rdata = w_status;
      ADDR_CONTEND: reg_rdata = r_cont_cnt;
      default: ;
    endcase
  end

  for (genvar o = 0; o < NUM_OUT; o++) begin : g_fifo
    router_out_fifo #(
      .DATA_W     (DATA_W),
      .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (w_push[o]),
      .i_wdata (w_push_data[o]),
      .i_pop   (out_ready[o]),
      .o_rdata (out_data[o*DATA_W +: DATA_W]),
      .full    (w_full[o]),
      .empty   (w_empty[o])
    );
  end

  assign out_valid = ~w_empty;

endmodule

// File: tb/tb_multi_port_router.sv
// Directed bench for multi_port_router (4 in, 4 out, 8-bit, depth 4).
// Expected output beats go into a scoreboard when stimulus is driven and are
// retired by a monitor whenever an output handshake completes.
module tb_multi_port_router;
  import router_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  reg_addr;
  logic [31:0] reg_wdata;
  logic        reg_en;
  logic        reg_we;
  logic [31:0] reg_rdata;
  logic [31:0] in_data;
  logic [7:0]  in_addr;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic [31:0] out_data;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;

  typedef struct {
    int         port;
    logic [7:0] data;
  } sb_t;

  sb_t sb[$];
  int  n_tests = 0;
  int  n_fail  = 0;

  multi_port_router #(
    .NUM_IN(4), .NUM_OUT(4), .DATA_W(8), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_en(reg_en), .reg_we(reg_we),
    .reg_rdata(reg_rdata),
    .in_data(in_data), .in_addr(in_addr), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input int i, input logic v, input logic [1:0] a, input logic [7:0] d);
    in_valid[i]       = v;
    in_addr[i*2 +: 2] = a;
    in_data[i*8 +: 8] = d;
  endtask

  task automatic exp_beat(input int port, input logic [7:0] d);
    sb_t e;
    e.port = port;
    e.data = d;
    sb.push_back(e);
  endtask

  task automatic reg_wr(input logic [3:0] a, input logic [31:0] d);
    reg_addr = a; reg_wdata = d; reg_en = 1'b1; reg_we = 1'b1;
    tick();
    reg_en = 1'b0; reg_we = 1'b0;
  endtask

  task automatic reg_rd(input logic [3:0] a, input logic [31:0] exp, input string tag);
    reg_addr = a; reg_en = 1'b1; reg_we = 1'b0;
    @(negedge clk);
    check(tag, reg_rdata, exp);
    tick();
    reg_en = 1'b0;
  endtask

  // Output monitor: every completed output handshake must match the oldest
  // expected beat queued for that port.
  always @(negedge clk) begin
    int idx;
    if (rst_n === 1'b1) begin
      for (int o = 0; o < 4; o++) begin
        if (out_valid[o] && out_ready[o]) begin
          idx = -1;
          for (int k = 0; k < sb.size(); k++) begin
            if (idx < 0 && sb[k].port == o) idx = k;
          end
          n_tests++;
          assert (idx >= 0) else begin
            n_fail++;
            $error("FAIL out%0d_unexpected: observed beat 0x%0h expected none", o, out_data[o*8 +: 8]);
          end
          if (idx >= 0) begin
            check($sformatf("out%0d_data", o), {24'd0, out_data[o*8 +: 8]}, {24'd0, sb[idx].data});
            sb.delete(idx);
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int exp_g [5];

    rst_n = 1'b0; reg_addr = '0; reg_wdata = '0; reg_en = 1'b0; reg_we = 1'b0;
    in_data = '0; in_addr = '0; in_valid = '0; out_ready = 4'hF;

    // Reset state, with a request held during reset.
    set_in(0, 1'b1, 2'd2, 8'h99);
    repeat (2) tick();
    @(negedge clk);
    check("rst_in_ready",  {28'd0, in_ready},  32'h0);
    check("rst_out_valid", {28'd0, out_valid}, 32'h0);
    check("rst_out_data",  out_data,           32'h0);
    tick();
    in_valid = '0;
    rst_n = 1'b1;
    reg_rd(ADDR_CTRL,    32'h1, "rst_ctrl");
    reg_rd(ADDR_STATUS,  32'h0, "rst_status");
    reg_rd(ADDR_CONTEND, 32'h0, "rst_contend");

    // Single beat in0 -> out2 with one-cycle latency.
    set_in(0, 1'b1, 2'd2, 8'hA5);
    exp_beat(2, 8'hA5);
    @(negedge clk);
    check("t1_in_ready",     {28'd0, in_ready},  32'h1);
    check("t1_valid_before", {28'd0, out_valid}, 32'h0);
    tick();
    in_valid = '0;
    @(negedge clk);
    check("t1_out_valid", {28'd0, out_valid},       32'h4);
    check("t1_out_data",  {24'd0, out_data[23:16]}, 32'hA5);
    tick();
    @(negedge clk);
    check("t1_valid_after", {28'd0, out_valid}, 32'h0);
    tick();

    // Fixed priority: in1 and in3 contend for out0.
    set_in(1, 1'b1, 2'd0, 8'h11);
    set_in(3, 1'b1, 2'd0, 8'h33);
    @(negedge clk);
    check("t2_grant_in1", {28'd0, in_ready}, 32'h2);
    exp_beat(0, 8'h11);
    tick();
    in_valid[1] = 1'b0;
    @(negedge clk);
    check("t2_grant_in3", {28'd0, in_ready}, 32'h8);
    exp_beat(0, 8'h33);
    tick();
    in_valid[3] = 1'b0;
    reg_rd(ADDR_CONTEND, 32'h1, "t2_contend");

    // Round-robin across all inputs to out1 (fixed-only builds keep in0).
    reg_wr(ADDR_CTRL, 32'h3);
`ifdef ROUTER_RR_ARB_EN
    reg_rd(ADDR_CTRL, 32'h3, "t3_ctrl_rr");
    exp_g = '{0, 1, 2, 3, 0};
`else
    reg_rd(ADDR_CTRL, 32'h1, "t3_ctrl_mode_ro");
    exp_g = '{0, 0, 0, 0, 0};
`endif
    for (int i = 0; i < 4; i++) set_in(i, 1'b1, 2'd1, 8'h40 + 8'(i));
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("t3_grant%0d", k), {28'd0, in_ready}, 32'h1 << exp_g[k]);
      exp_beat(1, 8'h40 + 8'(exp_g[k]));
      tick();
    end
    in_valid = '0;
    reg_rd(ADDR_CONTEND, 32'h6, "t3_contend");
    reg_wr(ADDR_CTRL, 32'h1);

    // Backpressure on out3: four beats fill the FIFO, the fifth waits.
    out_ready[3] = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      set_in(0, 1'b1, 2'd3, 8'(k));
      @(negedge clk);
      check($sformatf("t4_accept%0d", k), {28'd0, in_ready}, 32'h1);
      exp_beat(3, 8'(k));
      tick();
    end
    set_in(0, 1'b1, 2'd3, 8'h05);
    @(negedge clk);
    check("t4_held", {28'd0, in_ready}, 32'h0);
    reg_rd(ADDR_STATUS, 32'h0008_0008, "t4_status_full");
    out_ready[3] = 1'b1;
    @(negedge clk);
    check("t4_full_pop_same_cycle", {28'd0, in_ready}, 32'h0);
    tick();
    @(negedge clk);
    check("t4_fifth_accept", {28'd0, in_ready}, 32'h1);
    exp_beat(3, 8'h05);
    tick();
    in_valid = '0;
    repeat (6) tick();
    check("t4_drained", sb.size(), 32'h0);
    reg_rd(ADDR_STATUS, 32'h0, "t4_status_empty");

    // Disable with two entries queued on out2; they still drain.
    out_ready[2] = 1'b0;
    set_in(0, 1'b1, 2'd2, 8'h21);
    @(negedge clk);
    check("t5_accept0", {28'd0, in_ready}, 32'h1);
    exp_beat(2, 8'h21);
    tick();
    set_in(0, 1'b1, 2'd2, 8'h22);
    @(negedge clk);
    check("t5_accept1", {28'd0, in_ready}, 32'h1);
    exp_beat(2, 8'h22);
    tick();
    in_valid = '0;
    reg_wr(ADDR_CTRL, 32'h0);
    set_in(0, 1'b1, 2'd2, 8'h23);
    set_in(1, 1'b1, 2'd0, 8'h24);
    @(negedge clk);
    check("t5_ready_disabled", {28'd0, in_ready},  32'h0);
    check("t5_queued",         {28'd0, out_valid}, 32'h4);
    tick();
    out_ready[2] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("t5_ready_low%0d", k), {28'd0, in_ready}, 32'h0);
      tick();
    end
    check("t5_drained", sb.size(), 32'h0);
    check("t5_out_idle", {28'd0, out_valid}, 32'h0);
    in_valid = '0;
    reg_wr(ADDR_CONTEND, 32'hDEAD_BEEF);
    reg_rd(ADDR_CONTEND, 32'h0, "t5_contend_cleared");
    reg_wr(ADDR_CTRL, 32'h1);

    // Reset mid-operation discards queued data.
    out_ready[2] = 1'b0;
    set_in(0, 1'b1, 2'd2, 8'h31);
    tick();
    set_in(0, 1'b1, 2'd2, 8'h32);
    tick();
    rst_n = 1'b0;
    @(negedge clk);
    check("t6_ready_in_reset", {28'd0, in_ready}, 32'h0);
    tick();
    @(negedge clk);
    check("t6_valid_in_reset", {28'd0, out_valid}, 32'h0);
    check("t6_data_in_reset",  out_data,           32'h0);
    tick();
    in_valid = '0;
    rst_n = 1'b1;
    out_ready = 4'hF;
    @(negedge clk);
    check("t6_discarded", {28'd0, out_valid}, 32'h0);
    tick();
    reg_rd(ADDR_STATUS, 32'h0, "t6_status");

    check("final_sb_empty", sb.size(), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
